// File: rtl/apb_cmd_sequencer.sv
// rtl/apb_cmd_sequencer.sv - queued write/read/poll command engine for a single-transaction APB master
// Commands pass through a small FIFO and are issued one at a time; each gets exactly one in-order response.
module apb_cmd_sequencer #(
  parameter int DEPTH    = 4,
  parameter int POLL_MAX = 1024,
  parameter int POLL_GAP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [11:0] cmd_addr,
  input  logic [31:0] cmd_data,
  input  logic [31:0] cmd_mask,
  output logic        m_start,
  output logic        m_rw,
  output logic [11:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_idle,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_timeout,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(POLL_MAX + 1);
  localparam int GW = (POLL_GAP < 2) ? 1 : $clog2(POLL_GAP);
  localparam logic [AW:0]   FULL     = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] ATT_MAX  = CW'(POLL_MAX);
  localparam logic [GW-1:0] GAP_LOAD = GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_GAP, S_RESP} state_t;

  logic [77:0]   r_fifo [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;

  state_t        r_state;
  logic [1:0]    r_op;
  logic [31:0]   r_data, r_mask;
  logic [CW-1:0] r_attempt;
  logic [GW-1:0] r_gap;
  logic          r_start, r_rw, r_rsp_valid, r_rsp_timeout;
  logic [11:0]   r_addr;
  logic [31:0]   r_wdata, r_rsp_data;

  logic          w_push, w_pop, w_match;
  logic [77:0]   w_head;
  logic [CW-1:0] w_att_nxt;

  assign cmd_ready   = (r_count != FULL);
  assign busy        = (r_count != '0) || (r_state != S_IDLE);
  assign w_push      = cmd_valid && cmd_ready;
  assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
  assign w_head      = r_fifo[r_rd_ptr];
  assign w_match     = ((m_rdata & r_mask) == (r_data & r_mask));
  assign w_att_nxt   = r_attempt + CW'(1);

  assign m_start     = r_start;
  assign m_rw        = r_rw;
  assign m_addr      = r_addr;
  assign m_wdata     = r_wdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign rsp_timeout = r_rsp_timeout;

  // Storage needs no reset: entries are only read below the count.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= {cmd_op, cmd_addr, cmd_data, cmd_mask};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_op          <= '0;
      r_data        <= '0;
      r_mask        <= '0;
      r_attempt     <= '0;
      r_gap         <= '0;
      r_start       <= 1'b0;
      r_rw          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_start     <= 1'b0;
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_op      <= w_head[77:76];
            r_rw      <= (w_head[77:76] == 2'b00);
            r_addr    <= w_head[75:64];
            r_wdata   <= w_head[63:32];
            r_data    <= w_head[63:32];
            r_mask    <= w_head[31:0];
            r_attempt <= '0;
            r_start   <= 1'b1;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: r_state <= S_WAIT_ACK;
        S_WAIT_ACK: begin
          if (!m_idle) r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (m_idle) begin
            r_rsp_timeout <= 1'b0;
            r_rsp_data    <= m_rdata;
            if (r_op == 2'b00) begin
              r_rsp_data  <= '0;
              r_rsp_valid <= 1'b1;
              r_state     <= S_RESP;
            end else if (r_op == 2'b10) begin
              r_attempt <= w_att_nxt;
              if (w_match) begin
                r_rsp_valid <= 1'b1;
                r_state     <= S_RESP;
              end else if (w_att_nxt >= ATT_MAX) begin
                r_rsp_timeout <= 1'b1;
                r_rsp_valid   <= 1'b1;
                r_state       <= S_RESP;
              end else begin
                r_gap   <= GAP_LOAD;
                r_state <= S_GAP;
              end
            end else begin
              r_rsp_valid <= 1'b1;
              r_state     <= S_RESP;
            end
          end
        end
        S_GAP: begin
          if (r_gap == '0) begin
            r_start <= 1'b1;
            r_state <= S_ISSUE;
          end else begin
            r_gap <= r_gap - GW'(1);
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// tb/tb_apb_cmd_sequencer.sv - scoreboard bench for apb_cmd_sequencer with a behavioural APB master
// Vector table drives mixed commands; hand sequences cover backpressure and reset mid-poll.
module tb_apb_cmd_sequencer;
  localparam int DEPTH    = 4;
  localparam int POLL_MAX = 4;
  localparam int POLL_GAP = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_data, cmd_mask;
  logic        m_start, m_rw;
  logic [11:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata = '0;
  logic        m_idle = 1'b1;
  logic        rsp_valid, rsp_timeout, busy;
  logic [31:0] rsp_data;

  always #5 clk = ~clk;

  apb_cmd_sequencer #(.DEPTH(DEPTH), .POLL_MAX(POLL_MAX), .POLL_GAP(POLL_GAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .m_start(m_start), .m_rw(m_rw), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_idle(m_idle),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
    .busy(busy)
  );

  typedef struct { logic rw; logic [11:0] addr; logic [31:0] wdata; logic poll_rep; } txn_t;
  typedef struct { logic [31:0] data; logic timeout; logic [11:0] addr; } rsp_t;
  typedef struct {
    logic [1:0] op; logic [11:0] addr; logic [31:0] data; logic [31:0] mask;
    int nrd; logic [3:0][31:0] rd; logic [31:0] exp_data; logic exp_to;
  } vec_t;

  txn_t        exp_txn[$];
  rsp_t        exp_rsp[$];
  logic [31:0] slave_rd[$];
  vec_t        vecs[9];

  int errors = 0;
  int checks = 0;
  int stall = 0;
  int busy_cnt = 0;
  int low_cnt = 100;
  int n_start = 0;
  int n_rsp = 0;
  logic [31:0] cur_rd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural master: busy for 2+stall cycles after a start, rdata valid on return to idle.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_idle   = 1'b1;
      busy_cnt = 0;
    end else if (m_idle && m_start) begin
      m_idle   = 1'b0;
      busy_cnt = 1 + stall;
      cur_rd   = (slave_rd.size() > 0) ? slave_rd.pop_front() : 32'hBAD0_BAD0;
    end else if (!m_idle) begin
      if (busy_cnt == 0) begin
        m_idle  = 1'b1;
        m_rdata = cur_rd;
      end else begin
        busy_cnt--;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      low_cnt = 100;
    end else begin
      if (m_start) begin
        txn_t t;
        n_start++;
        if (exp_txn.size() == 0) begin
          chk("start_unexpected", 32'd1, 32'd0);
        end else begin
          t = exp_txn.pop_front();
          chk("m_rw", {31'd0, m_rw}, {31'd0, t.rw});
          chk("m_addr", {20'd0, m_addr}, {20'd0, t.addr});
          chk("m_wdata", m_wdata, t.wdata);
          chk("start_low_min2", {31'd0, (low_cnt >= 2)}, 32'd1);
          if (t.poll_rep) chk("poll_gap", {31'd0, (low_cnt >= POLL_GAP)}, 32'd1);
        end
        low_cnt = 0;
      end else begin
        low_cnt++;
      end
      if (rsp_valid) begin
        rsp_t r;
        n_rsp++;
        if (exp_rsp.size() == 0) begin
          chk("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          r = exp_rsp.pop_front();
          chk("rsp_data", rsp_data, r.data);
          chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, r.timeout});
          chk("m_addr_stable", {20'd0, m_addr}, {20'd0, r.addr});
        end
      end
    end
  end

  task automatic push_cmd(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d,
                          input logic [31:0] m, output int waited);
    waited = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_mask  = m;
    while (!cmd_ready && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) chk("push_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic expect_cmd(input vec_t v);
    txn_t t;
    rsp_t r;
    for (int j = 0; j < v.nrd; j++) begin
      slave_rd.push_back(v.rd[j]);
      t.rw = (v.op == 2'b00);
      t.addr = v.addr;
      t.wdata = v.data;
      t.poll_rep = (j > 0);
      exp_txn.push_back(t);
    end
    r.data = v.exp_data;
    r.timeout = v.exp_to;
    r.addr = v.addr;
    exp_rsp.push_back(r);
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((exp_rsp.size() != 0 || busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_rsp_left"}, exp_rsp.size(), 32'd0);
    chk({name, "_txn_left"}, exp_txn.size(), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    int rsp_b, start_b, tw;
    vec_t v;
    cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0; cmd_mask = '0;

    vecs[0] = '{2'b00, 12'h010, 32'hDEADBEEF, 32'h0, 1, {32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF}, 32'h0, 1'b0};
    vecs[1] = '{2'b01, 12'h004, 32'h0, 32'h0, 1, {32'h0, 32'h0, 32'h0, 32'h1234_5678}, 32'h1234_5678, 1'b0};
    vecs[2] = '{2'b10, 12'h008, 32'h0, 32'h1, 4, {32'h0, 32'h1, 32'h1, 32'h1}, 32'h0, 1'b0};
    vecs[3] = '{2'b10, 12'h00C, 32'h0, 32'h1, 4, {32'h1, 32'h1, 32'h1, 32'h1}, 32'h1, 1'b1};
    vecs[4] = '{2'b10, 12'h020, 32'h1200, 32'hFF00, 1, {32'h0, 32'h0, 32'h0, 32'h12AB}, 32'h12AB, 1'b0};
    vecs[5] = '{2'b11, 12'h0FF, 32'h0, 32'h0, 1, {32'h0, 32'h0, 32'h0, 32'hCAFE_F00D}, 32'hCAFE_F00D, 1'b0};
    vecs[6] = '{2'b10, 12'h030, 32'hFFFF, 32'h0, 1, {32'h0, 32'h0, 32'h0, 32'h5555}, 32'h5555, 1'b0};
    vecs[7] = '{2'b00, 12'hFFF, 32'h0, 32'h0, 1, {32'h0, 32'h0, 32'h0, 32'h77}, 32'h0, 1'b0};
    vecs[8] = '{2'b10, 12'h040, 32'h8000_0000, 32'h8000_0000, 3,
                {32'h0, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0}, 32'h8000_0000, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_m_start", {31'd0, m_start}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_m_addr", {20'd0, m_addr}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      expect_cmd(vecs[i]);
      push_cmd(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].mask, w);
    end
    cmd_valid = 1'b0;
    drain("table");
    chk("table_rsp_count", n_rsp, 32'd9);
    chk("table_start_count", n_start, 32'd17);

    // Backpressure: stalled master holds one command, DEPTH more fill the FIFO.
    stall = 20;
    for (int i = 0; i < DEPTH + 2; i++) begin
      v = '{2'b00, 12'h100 + 12'(i), 32'h1111_1111 * (i + 1), 32'h0, 1, '0, 32'h0, 1'b0};
      expect_cmd(v);
      if (i == DEPTH) chk("ready_before_full", {31'd0, cmd_ready}, 32'd1);
      push_cmd(v.op, v.addr, v.data, v.mask, w);
      if (i == DEPTH) begin
        chk("full_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("full_busy", {31'd0, busy}, 32'd1);
        stall = 0;
      end
      if (i == DEPTH + 1) chk("full_push_waited", {31'd0, (w > 0)}, 32'd1);
    end
    cmd_valid = 1'b0;
    drain("bp");
    chk("bp_rsp_count", n_rsp, 32'd15);

    // Reset while a poll read is outstanding, with more commands queued behind it.
    stall = 10;
    v = '{2'b10, 12'h008, 32'h0, 32'h1, 4, {32'h1, 32'h1, 32'h1, 32'h1}, 32'h1, 1'b1};
    expect_cmd(v);
    start_b = n_start;
    push_cmd(v.op, v.addr, v.data, v.mask, w);
    push_cmd(2'b00, 12'h200, 32'h1, 32'h0, w);
    push_cmd(2'b01, 12'h204, 32'h0, 32'h0, w);
    cmd_valid = 1'b0;
    tw = 0;
    while (n_start == start_b && tw < 100) begin
      @(negedge clk);
      tw++;
    end
    chk("mid_poll_started", {31'd0, (n_start > start_b)}, 32'd1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rr_m_start", {31'd0, m_start}, 32'd0);
    chk("rr_m_rw", {31'd0, m_rw}, 32'd0);
    chk("rr_m_addr", {20'd0, m_addr}, 32'd0);
    chk("rr_m_wdata", m_wdata, 32'd0);
    chk("rr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rr_rsp_data", rsp_data, 32'd0);
    chk("rr_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
    chk("rr_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rr_busy", {31'd0, busy}, 32'd0);
    exp_txn.delete();
    exp_rsp.delete();
    slave_rd.delete();
    stall = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rsp_b = n_rsp;
    start_b = n_start;
    repeat (40) @(negedge clk);
    chk("rr_no_rsp", n_rsp - rsp_b, 32'd0);
    chk("rr_no_start", n_start - start_b, 32'd0);
    chk("rr_busy_after", {31'd0, busy}, 32'd0);

    v = '{2'b01, 12'h004, 32'h0, 32'h0, 1, {32'h0, 32'h0, 32'h0, 32'hA5A5_A5A5}, 32'hA5A5_A5A5, 1'b0};
    expect_cmd(v);
    push_cmd(v.op, v.addr, v.data, v.mask, w);
    cmd_valid = 1'b0;
    drain("post_rst");
    chk("post_rst_rsp_count", n_rsp - rsp_b, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
